// File: rtl/deal_pkg.sv
// Shared types and constants for the baccarat round controller.
// Card ranks are 4-bit: 1=A .. 13=K, 0 = empty slot.
package deal_pkg;

  typedef enum logic [3:0] {
    IDLE,
    DEAL_P1,
    DEAL_D1,
    DEAL_P2,
    DEAL_D2,
    CHECK,
    DEAL_P3,
    BANK,
    DEAL_D3,
    RESULT,
    ERROR
  } deal_state_t;

  localparam logic [3:0] CARD_MIN    = 4'd1;
  localparam logic [3:0] CARD_MAX    = 4'd13;
  localparam logic [3:0] FACE_MIN    = 4'd10;
  localparam logic [3:0] NATURAL_MIN = 4'd8;
  localparam logic [3:0] DRAW_MAX    = 4'd5;

  // Baccarat point value of a rank: tens and face cards count as zero.
  function automatic logic [3:0] card_value(input logic [3:0] card);
    return (card >= FACE_MIN) ? 4'd0 : card;
  endfunction

endpackage

// File: rtl/bank_rule.sv
// Banker third-card table, used only after the player has drawn a third card.
module bank_rule
  import deal_pkg::*;
(
  input  logic [3:0] dscore,
  input  logic [3:0] pcard3,
  output logic       draw
);

  logic [3:0] v;

  // Banker decision from the banker total and the point value of the player's third card.
  always_comb begin
    v    = card_value(pcard3);
    draw = 1'b0;
    case (dscore)
      4'd0, 4'd1, 4'd2: draw = 1'b1;
      4'd3:             draw = (v != 4'd8);
      4'd4:             draw = (v >= 4'd2) && (v <= 4'd7);
      4'd5:             draw = (v >= 4'd4) && (v <= 4'd7);
      4'd6:             draw = (v >= 4'd6) && (v <= 4'd7);
      default:          draw = 1'b0;
    endcase
  end

endmodule

// File: rtl/scorehand.sv
// Hand total (mod 10) of up to three cards; empty slots (0) add nothing.
module scorehand
  import deal_pkg::*;
(
  input  logic [3:0] card1,
  input  logic [3:0] card2,
  input  logic [3:0] card3,
  output logic [3:0] total
);

  logic [4:0] sum;
  logic [4:0] wrapped;

  // Sum of three values is at most 27, so two conditional subtractions reduce it mod 10.
  always_comb begin
    sum = {1'b0, card_value(card1)} + {1'b0, card_value(card2)} + {1'b0, card_value(card3)};
    if (sum >= 5'd20) begin
      wrapped = sum - 5'd20;
    end else if (sum >= 5'd10) begin
      wrapped = sum - 5'd10;
    end else begin
      wrapped = sum;
    end
    total = wrapped[3:0];
  end

endmodule

// File: rtl/deal_sequencer.sv
// Baccarat round controller: requests cards over a valid/ready style handshake,
// fills the six hand slots in dealing order, applies the third-card rules and
// reports the winner. Optional macro ROUND_STATS_EN adds win/tie counters.
module deal_sequencer
  import deal_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic       slow_clock,
  input  logic       resetb,
  input  logic       start,
  output logic       card_req,
  input  logic       card_valid,
  input  logic [3:0] card_in,
  output logic [3:0] pcard1,
  output logic [3:0] pcard2,
  output logic [3:0] pcard3,
  output logic [3:0] dcard1,
  output logic [3:0] dcard2,
  output logic [3:0] dcard3,
  output logic [3:0] pscore,
  output logic [3:0] dscore,
  output logic       busy,
  output logic       done,
  output logic       player_win,
  output logic       dealer_win,
  output logic       error
`ifdef ROUND_STATS_EN
  ,
  output logic [7:0] pwins,
  output logic [7:0] dwins,
  output logic [7:0] ties
`endif
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  deal_state_t state;
  deal_state_t state_next;

  logic [CNT_W-1:0] tmo_cnt;
  logic             tmo_hit;
  logic             card_ok;
  logic             accept;
  logic             bank_draw;

  scorehand u_player_score (
    .card1 (pcard1),
    .card2 (pcard2),
    .card3 (pcard3),
    .total (pscore)
  );

  scorehand u_dealer_score (
    .card1 (dcard1),
    .card2 (dcard2),
    .card3 (dcard3),
    .total (dscore)
  );

  bank_rule u_bank_rule (
    .dscore (dscore),
    .pcard3 (pcard3),
    .draw   (bank_draw)
  );

  assign card_ok = card_valid && (card_in >= CARD_MIN) && (card_in <= CARD_MAX);
  assign accept  = card_req && card_ok;
  assign tmo_hit = (TIMEOUT != 0) && (tmo_cnt == CNT_W'(TIMEOUT - 1));

  // State register.
  always_ff @(posedge slow_clock) begin
    if (!resetb) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state: dealing order, natural/draw decisions and the card wait timeout.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = DEAL_P1;
      DEAL_P1: if (accept) state_next = DEAL_D1; else if (tmo_hit) state_next = ERROR;
      DEAL_D1: if (accept) state_next = DEAL_P2; else if (tmo_hit) state_next = ERROR;
      DEAL_P2: if (accept) state_next = DEAL_D2; else if (tmo_hit) state_next = ERROR;
      DEAL_D2: if (accept) state_next = CHECK;   else if (tmo_hit) state_next = ERROR;
      CHECK: begin
        if ((pscore >= NATURAL_MIN) || (dscore >= NATURAL_MIN)) begin
          state_next = RESULT;
        end else if (pscore <= DRAW_MAX) begin
          state_next = DEAL_P3;
        end else if (dscore <= DRAW_MAX) begin
          state_next = DEAL_D3;
        end else begin
          state_next = RESULT;
        end
      end
      DEAL_P3: if (accept) state_next = BANK;    else if (tmo_hit) state_next = ERROR;
      BANK:    state_next = bank_draw ? DEAL_D3 : RESULT;
      DEAL_D3: if (accept) state_next = RESULT;  else if (tmo_hit) state_next = ERROR;
      RESULT:  state_next = IDLE;
      ERROR:   state_next = ERROR;
      default: state_next = IDLE;
    endcase
  end

  // Moore outputs decoded from the state.
  always_comb begin
    card_req = 1'b0;
    busy     = 1'b1;
    error    = 1'b0;
    case (state)
      DEAL_P1, DEAL_D1, DEAL_P2, DEAL_D2, DEAL_P3, DEAL_D3: card_req = 1'b1;
      IDLE:    busy = 1'b0;
      ERROR: begin
        busy  = 1'b0;
        error = 1'b1;
      end
      default: ;
    endcase
  end

  // Card slots, result lights, done pulse and the card wait counter.
  always_ff @(posedge slow_clock) begin
    if (!resetb) begin
      pcard1     <= 4'd0;
      pcard2     <= 4'd0;
      pcard3     <= 4'd0;
      dcard1     <= 4'd0;
      dcard2     <= 4'd0;
      dcard3     <= 4'd0;
      player_win <= 1'b0;
      dealer_win <= 1'b0;
      done       <= 1'b0;
      tmo_cnt    <= '0;
    end else begin
      done    <= 1'b0;
      tmo_cnt <= (card_req && !accept) ? tmo_cnt + 1'b1 : '0;
      case (state)
        IDLE: begin
          if (start) begin
            pcard1     <= 4'd0;
            pcard2     <= 4'd0;
            pcard3     <= 4'd0;
            dcard1     <= 4'd0;
            dcard2     <= 4'd0;
            dcard3     <= 4'd0;
            player_win <= 1'b0;
            dealer_win <= 1'b0;
          end
        end
        DEAL_P1: if (accept) pcard1 <= card_in;
        DEAL_D1: if (accept) dcard1 <= card_in;
        DEAL_P2: if (accept) pcard2 <= card_in;
        DEAL_D2: if (accept) dcard2 <= card_in;
        DEAL_P3: if (accept) pcard3 <= card_in;
        DEAL_D3: if (accept) dcard3 <= card_in;
        RESULT: begin
          player_win <= (pscore >= dscore);
          dealer_win <= (dscore >= pscore);
          done       <= 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef ROUND_STATS_EN
  // Saturating round statistics, bumped as each result is published.
  always_ff @(posedge slow_clock) begin
    if (!resetb) begin
      pwins <= 8'd0;
      dwins <= 8'd0;
      ties  <= 8'd0;
    end else if (state == RESULT) begin
      if (pscore == dscore) begin
        if (ties != 8'hFF) ties <= ties + 8'd1;
      end else if (pscore > dscore) begin
        if (pwins != 8'hFF) pwins <= pwins + 8'd1;
      end else begin
        if (dwins != 8'hFF) dwins <= dwins + 8'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_deal_sequencer.sv
// Scoreboard bench for deal_sequencer (TIMEOUT=4). Rounds push their expected
// result into a queue; a monitor pops and compares whenever done pulses.
module tb_deal_sequencer;

  typedef struct {
    logic [3:0] p1, p2, p3, d1, d2, d3, ps, ds;
    logic       pw, dw;
    int         cyc;
  } exp_t;

  logic       slow_clock = 1'b0;
  logic       resetb;
  logic       start;
  logic       card_valid;
  logic [3:0] card_in;
  logic       card_req;
  logic [3:0] pcard1, pcard2, pcard3, dcard1, dcard2, dcard3, pscore, dscore;
  logic       busy, done, player_win, dealer_win, error;
`ifdef ROUND_STATS_EN
  logic [7:0] pwins, dwins, ties;
`endif

  logic [3:0] br_dscore, br_pcard3;
  logic       br_draw;

  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc   = 0;
  exp_t exp_q[$];
  exp_t mon_e;
  logic [4:0] beat_q[$];

  deal_sequencer #(.TIMEOUT(4)) dut (
    .slow_clock (slow_clock),
    .resetb     (resetb),
    .start      (start),
    .card_req   (card_req),
    .card_valid (card_valid),
    .card_in    (card_in),
    .pcard1     (pcard1),
    .pcard2     (pcard2),
    .pcard3     (pcard3),
    .dcard1     (dcard1),
    .dcard2     (dcard2),
    .dcard3     (dcard3),
    .pscore     (pscore),
    .dscore     (dscore),
    .busy       (busy),
    .done       (done),
    .player_win (player_win),
    .dealer_win (dealer_win),
    .error      (error)
`ifdef ROUND_STATS_EN
    ,
    .pwins      (pwins),
    .dwins      (dwins),
    .ties       (ties)
`endif
  );

  bank_rule u_br (
    .dscore (br_dscore),
    .pcard3 (br_pcard3),
    .draw   (br_draw)
  );

  // Free-running clock and cycle counter.
  always #5 slow_clock = ~slow_clock;

  always @(posedge slow_clock) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("[TB] FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  // Banker table as per-total bit masks indexed by third-card point value.
  function automatic logic bankModel(input int d, input int rank);
    logic [9:0] m;
    int v;
    v = (rank >= 10) ? 0 : rank;
    case (d)
      0, 1, 2: m = 10'h3FF;
      3:       m = 10'h2FF;
      4:       m = 10'h0FC;
      5:       m = 10'h0F0;
      6:       m = 10'h0C0;
      default: m = 10'h000;
    endcase
    return m[v];
  endfunction

  function automatic exp_t mkExp(input logic [3:0] p1, p2, p3, d1, d2, d3, ps, ds,
                                 input logic pw, dw);
    exp_t e;
    e.p1 = p1; e.p2 = p2; e.p3 = p3;
    e.d1 = d1; e.d2 = d2; e.d3 = d3;
    e.ps = ps; e.ds = ds; e.pw = pw; e.dw = dw;
    e.cyc = 0;
    return e;
  endfunction

  function automatic void addCard(input logic [3:0] c);
    beat_q.push_back({1'b1, c});
  endfunction

  function automatic void addStall(input int n);
    for (int i = 0; i < n; i++) beat_q.push_back(5'h00);
  endfunction

  // Monitor: every done pulse is matched against the oldest expected round.
  always @(negedge slow_clock) begin
    if (done) begin
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_done", 1, 0);
      end else begin
        mon_e = exp_q.pop_front();
        checkOutput("pcard1", pcard1, mon_e.p1);
        checkOutput("pcard2", pcard2, mon_e.p2);
        checkOutput("pcard3", pcard3, mon_e.p3);
        checkOutput("dcard1", dcard1, mon_e.d1);
        checkOutput("dcard2", dcard2, mon_e.d2);
        checkOutput("dcard3", dcard3, mon_e.d3);
        checkOutput("pscore", pscore, mon_e.ps);
        checkOutput("dscore", dscore, mon_e.ds);
        checkOutput("player_win", player_win, mon_e.pw);
        checkOutput("dealer_win", dealer_win, mon_e.dw);
        checkOutput("busy_at_done", busy, 0);
        checkOutput("done_cycle", cyc, mon_e.cyc);
      end
    end
  end

  // Starts a round (called at a negedge) and feeds the queued beats whenever card_req is high.
  task automatic applyStimulus(input exp_t e, input int lat);
    int g;
    e.cyc = cyc + lat;
    exp_q.push_back(e);
    start = 1'b1;
    @(negedge slow_clock);
    start = 1'b0;
    while (beat_q.size() > 0) begin
      g = 0;
      if (!card_req) card_valid = 1'b0;
      while (!card_req && g < 20) begin
        @(negedge slow_clock);
        g++;
      end
      if (!card_req) begin
        checkOutput("card_req_wait", 0, 1);
        beat_q.delete();
        break;
      end
      {card_valid, card_in} = beat_q.pop_front();
      @(negedge slow_clock);
    end
    card_valid = 1'b0;
    card_in    = 4'd0;
    g = 0;
    while (!done && g < 40) begin
      @(negedge slow_clock);
      g++;
    end
    if (!done) begin
      checkOutput("done_wait", 0, 1);
      exp_q.delete();
    end
    @(negedge slow_clock);
  endtask

  task automatic checkCleared(input string tag);
    checkOutput({tag, "_pcard1"}, pcard1, 0);
    checkOutput({tag, "_pcard2"}, pcard2, 0);
    checkOutput({tag, "_pcard3"}, pcard3, 0);
    checkOutput({tag, "_dcard1"}, dcard1, 0);
    checkOutput({tag, "_dcard2"}, dcard2, 0);
    checkOutput({tag, "_dcard3"}, dcard3, 0);
    checkOutput({tag, "_pwin"}, player_win, 0);
    checkOutput({tag, "_dwin"}, dealer_win, 0);
    checkOutput({tag, "_done"}, done, 0);
    checkOutput({tag, "_error"}, error, 0);
    checkOutput({tag, "_busy"}, busy, 0);
    checkOutput({tag, "_card_req"}, card_req, 0);
  endtask

  // Main directed sequence.
  initial begin
    int n;
    int g;
    resetb     = 1'b0;
    start      = 1'b0;
    card_valid = 1'b0;
    card_in    = 4'd0;
    br_dscore  = 4'd0;
    br_pcard3  = 4'd0;

    for (int d = 0; d < 10; d++) begin
      for (int c = 1; c < 14; c++) begin
        br_dscore = 4'(d);
        br_pcard3 = 4'(c);
        #1;
        checkOutput($sformatf("bank_d%0d_c%0d", d, c), br_draw, bankModel(d, c));
      end
    end

    repeat (2) @(negedge slow_clock);
    checkCleared("reset");
    resetb = 1'b1;
    @(negedge slow_clock);

    // Natural: P 8+K=8, D 3+4=7.
    addCard(4'd8); addCard(4'd3); addCard(4'd13); addCard(4'd4);
    applyStimulus(mkExp(8, 13, 0, 3, 4, 0, 8, 7, 1, 0), 7);

    // Player draws 4 to reach 9, banker on 6 stands against v=4.
    addCard(4'd2); addCard(4'd3); addCard(4'd3); addCard(4'd3); addCard(4'd4);
    applyStimulus(mkExp(2, 3, 4, 3, 3, 0, 9, 6, 1, 0), 9);

    // Player stands on 6, banker on 4 draws 5 to reach 9.
    addCard(4'd3); addCard(4'd2); addCard(4'd3); addCard(4'd2); addCard(4'd5);
    applyStimulus(mkExp(3, 3, 0, 2, 2, 5, 6, 9, 0, 1), 8);

    // Tie on 7 with face cards, both stand.
    addCard(4'd7); addCard(4'd7); addCard(4'd12); addCard(4'd13);
    applyStimulus(mkExp(7, 12, 0, 7, 13, 0, 7, 7, 1, 1), 7);

    // All aces: six cards, tie on 3.
    for (int i = 0; i < 6; i++) addCard(4'd1);
    applyStimulus(mkExp(1, 1, 1, 1, 1, 1, 3, 3, 1, 1), 10);

    // Reset while idle clears held lights and cards.
    resetb = 1'b0;
    @(negedge slow_clock);
    resetb = 1'b1;
    checkCleared("idle_reset");

    // Invalid ranks dropped, then a 3-cycle stall; natural 8 vs 8.
    addCard(4'd0); addCard(4'd14); addCard(4'd15);
    addCard(4'd5); addCard(4'd2); addStall(3); addCard(4'd3); addCard(4'd6);
    applyStimulus(mkExp(5, 3, 0, 2, 6, 0, 8, 8, 1, 1), 13);

    // Reset mid-round while waiting in DEAL_D2.
    start = 1'b1;
    @(negedge slow_clock);
    start      = 1'b0;
    card_valid = 1'b1;
    card_in    = 4'd4;
    @(negedge slow_clock);
    card_in = 4'd5;
    @(negedge slow_clock);
    card_in = 4'd6;
    @(negedge slow_clock);
    card_valid = 1'b0;
    card_in    = 4'd0;
    checkOutput("d2_card_req", card_req, 1);
    checkOutput("d2_pcard2", pcard2, 6);
    resetb = 1'b0;
    @(negedge slow_clock);
    resetb = 1'b1;
    checkCleared("mid_reset");
    repeat (12) @(negedge slow_clock);
    checkOutput("after_mid_reset_busy", busy, 0);

    // Timeout: no cards offered.
    start = 1'b1;
    @(negedge slow_clock);
    start = 1'b0;
    n = 0;
    g = 0;
    while (!error && g < 20) begin
      if (card_req) n++;
      @(negedge slow_clock);
      g++;
    end
    checkOutput("timeout_req_cycles", n, 4);
    checkOutput("timeout_error", error, 1);
    checkOutput("timeout_card_req", card_req, 0);
    checkOutput("timeout_busy", busy, 0);
    start      = 1'b1;
    card_valid = 1'b1;
    card_in    = 4'd9;
    @(negedge slow_clock);
    start = 1'b0;
    repeat (3) @(negedge slow_clock);
    card_valid = 1'b0;
    checkOutput("error_hold", error, 1);
    checkOutput("error_start_ignored", card_req, 0);
    checkOutput("error_pcard1", pcard1, 0);
    resetb = 1'b0;
    @(negedge slow_clock);
    resetb = 1'b1;
    checkCleared("error_reset");

    repeat (2) @(negedge slow_clock);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Global time bound.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

endmodule
